// File: rtl/paicore_loopback_mc.sv
// Multi-channel loopback: unpacks input beats into 32-bit words, spreads them round-robin over
// per-channel FIFOs, collects them in the same order and repacks. Optional stats: PAICORE_LOOPBACK_STATS_EN.
module paicore_loopback_mc #(
  parameter int CHANNEL    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CHANNEL-1:0]      oen,
  input  logic                    single_channel,
  input  logic [CHANNEL-1:0]      single_channel_mask,
  input  logic [31:0]             send_len,
  input  logic [31:0]             frame_num_max,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  output logic                    o_busy,
  output logic                    o_tx_done,
  output logic                    o_rx_done
`ifdef PAICORE_LOOPBACK_STATS_EN
  ,
  output logic [31:0]             o_drop_cnt,
  output logic [CHANNEL*16-1:0]   o_ch_words
`endif
);

  localparam int W   = DATA_WIDTH / 32;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CHW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam int KW  = (W > 1) ? $clog2(W) : 1;
  localparam int FW  = $clog2(W + 1);
  localparam int CW  = 40;  // word counters: send_len * W can exceed 32 bits
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [CHANNEL-1:0]      mask_q;
  logic [31:0]             send_len_q, fnm_q, acc_cnt;
  logic [CW-1:0]           pop_cnt;
  logic [DATA_WIDTH-1:0]   unpack_data;
  logic                    unpack_valid;
  logic [KW-1:0]           unpack_idx;
  logic [CHW-1:0]          disp_ch, col_ch;
  logic [31:0]             mem [CHANNEL][FIFO_DEPTH];
  logic [AW:0]             wr_ptr [CHANNEL];
  logic [AW:0]             rd_ptr [CHANNEL];
  logic [FW-1:0]           fill;

  logic                    unused;
  assign unused = s_axis_tlast;

  // Next active channel strictly after cur, wrapping; the start pointer is found from CHANNEL-1.
  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] cur, input logic [CHANNEL-1:0] mask);
    logic [CHW-1:0] res;
    logic           found;
    int             idx;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= CHANNEL; i++) begin
      idx = (int'(cur) + i) % CHANNEL;
      if (!found && mask[idx]) begin
        res   = CHW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  logic [CHANNEL-1:0]    sel_mask, fifo_empty, fifo_full;
  logic                  start_take, accept, active, limited, pop, push, pack;
  logic                  hit_limit, is_last_in, all_empty, drain_done, hs;
  logic [CW-1:0]         word_no, total_words;
  logic [31:0]           pop_word, push_word;
  logic [DATA_WIDTH-1:0] data_n;
  logic [FW-1:0]         fill_n;
  logic                  valid_n, last_n;

  assign sel_mask      = single_channel ? single_channel_mask : oen;
  assign start_take    = (state == IDLE) && start && (sel_mask != '0);
  assign s_axis_tready = (state == RUN) && !unpack_valid && (acc_cnt < send_len_q);
  assign accept        = s_axis_tready && s_axis_tvalid;
  assign active        = (state == RUN) || (state == DRAIN);

  always_comb begin
    for (int c = 0; c < CHANNEL; c++) begin
      fifo_empty[c] = (wr_ptr[c] == rd_ptr[c]);
      fifo_full[c]  = ((wr_ptr[c] - rd_ptr[c]) == DEPTH_V);
    end
  end
  assign all_empty = &fifo_empty;

  // Past the frame limit the collector discards, so it no longer waits on the output register.
  assign limited     = (fnm_q != '0) && (pop_cnt >= CW'(fnm_q));
  assign pop         = active && !fifo_empty[col_ch] && (limited || !(m_axis_tvalid && !m_axis_tready));
  assign pop_word    = mem[col_ch][rd_ptr[col_ch][AW-1:0]];
  assign word_no     = pop_cnt + CW'(1);
  assign total_words = CW'(send_len_q) * CW'(W);
  assign hit_limit   = (fnm_q != '0) && (word_no == CW'(fnm_q));
  assign is_last_in  = (word_no == total_words);
  assign pack        = pop && !limited;
  assign push        = unpack_valid && (!fifo_full[disp_ch] || (pop && (col_ch == disp_ch)));
  assign push_word   = unpack_data[32*unpack_idx +: 32];
  assign drain_done  = (state == DRAIN) && !unpack_valid && all_empty && !m_axis_tvalid && (fill == '0);

  // NOTE: every variable gets a default before the conditional updates, so no latch is inferred.
  always_comb begin
    hs      = m_axis_tvalid && m_axis_tready;
    data_n  = hs ? '0 : m_axis_tdata;
    fill_n  = fill;
    valid_n = m_axis_tvalid && !hs;
    last_n  = m_axis_tlast && !hs;
    if (pack) begin
      data_n[32*fill +: 32] = pop_word;
      fill_n = fill + 1'b1;
      if (fill_n == FW'(W) || hit_limit || is_last_in) begin
        valid_n = 1'b1;
        last_n  = hit_limit || ((fnm_q == '0) && is_last_in);
        fill_n  = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in a cycle win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_tx_done    <= 1'b0;
      o_rx_done    <= 1'b0;
      mask_q       <= '0;
      send_len_q   <= '0;
      fnm_q        <= '0;
      acc_cnt      <= '0;
      pop_cnt      <= '0;
      unpack_data  <= '0;
      unpack_valid <= 1'b0;
      unpack_idx   <= '0;
      disp_ch      <= '0;
      col_ch       <= '0;
    end else begin
      o_tx_done <= 1'b0;
      o_rx_done <= 1'b0;
      case (state)
        IDLE: if (start_take) begin
          state      <= RUN;
          o_busy     <= 1'b1;
          mask_q     <= sel_mask;
          send_len_q <= send_len;
          fnm_q      <= frame_num_max;
          acc_cnt    <= '0;
          pop_cnt    <= '0;
          disp_ch    <= next_ch(CHW'(CHANNEL - 1), sel_mask);
          col_ch     <= next_ch(CHW'(CHANNEL - 1), sel_mask);
          o_tx_done  <= (send_len == '0);
        end
        RUN: begin
          if (send_len_q == '0) begin
            state <= DRAIN;
          end else if (accept && (acc_cnt + 32'd1 == send_len_q)) begin
            state     <= DRAIN;
            o_tx_done <= 1'b1;
          end
        end
        DRAIN: if (drain_done) begin
          state     <= DONE;
          o_busy    <= 1'b0;
          o_rx_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        unpack_data  <= s_axis_tdata;
        unpack_valid <= 1'b1;
        unpack_idx   <= '0;
        acc_cnt      <= acc_cnt + 32'd1;
      end else if (push) begin
        if (unpack_idx == KW'(W - 1)) begin
          unpack_valid <= 1'b0;
          unpack_idx   <= '0;
        end else begin
          unpack_idx <= unpack_idx + 1'b1;
        end
        disp_ch <= next_ch(disp_ch, mask_q);
      end

      if (pop) begin
        col_ch  <= next_ch(col_ch, mask_q);
        pop_cnt <= pop_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNEL; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else begin
      if (push) wr_ptr[disp_ch] <= wr_ptr[disp_ch] + 1'b1;
      if (pop)  rd_ptr[col_ch]  <= rd_ptr[col_ch] + 1'b1;
    end
  end

  // NOTE: storage is not reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[disp_ch][wr_ptr[disp_ch][AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      fill          <= '0;
    end else begin
      m_axis_tdata  <= data_n;
      m_axis_tlast  <= last_n;
      m_axis_tvalid <= valid_n;
      fill          <= fill_n;
    end
  end

`ifdef PAICORE_LOOPBACK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_drop_cnt <= '0;
      o_ch_words <= '0;
    end else if (start_take) begin
      o_drop_cnt <= '0;
      o_ch_words <= '0;
    end else begin
      if (pop && limited) o_drop_cnt <= o_drop_cnt + 32'd1;
      if (push && (o_ch_words[16*disp_ch +: 16] != 16'hFFFF))
        o_ch_words[16*disp_ch +: 16] <= o_ch_words[16*disp_ch +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_paicore_loopback_mc.sv
// Scoreboard bench for paicore_loopback_mc: a word-list model predicts output beats, a monitor
// pops and compares them on every handshake.
module tb_paicore_loopback_mc;
  localparam int CH = 4;
  localparam int DW = 64;
  localparam int DEPTH = 4;
  localparam int W = DW / 32;

  logic          clk, rst, start, single_channel;
  logic [CH-1:0] oen, single_channel_mask;
  logic [31:0]   send_len, frame_num_max;
  logic          s_tready, s_tlast, s_tvalid, m_tready, m_tlast, m_tvalid;
  logic [DW-1:0] s_tdata, m_tdata;
  logic          o_busy, o_tx_done, o_rx_done;
`ifdef PAICORE_LOOPBACK_STATS_EN
  logic [31:0]     o_drop_cnt;
  logic [CH*16-1:0] o_ch_words;
`endif

  paicore_loopback_mc #(.CHANNEL(CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .oen(oen), .single_channel(single_channel),
    .single_channel_mask(single_channel_mask), .send_len(send_len), .frame_num_max(frame_num_max),
    .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .o_busy(o_busy), .o_tx_done(o_tx_done), .o_rx_done(o_rx_done)
`ifdef PAICORE_LOOPBACK_STATS_EN
    , .o_drop_cnt(o_drop_cnt), .o_ch_words(o_ch_words)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int tx_cnt = 0;
  int rx_cnt = 0;
  int ready_mode = 0;
  int stall_cnt = 0;
  int exp_drop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output sink pattern: 0 always ready, 1 toggle, 2 random, 3 stalled for 200 cycles.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_tready = 1'b1;
      1: m_tready = !m_tready;
      2: m_tready = 1'($urandom_range(0, 1));
      default: begin
        m_tready = (stall_cnt >= 200);
        stall_cnt++;
      end
    endcase
  end

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_data);
        check("hold_last", m_tlast, prev_last);
      end
      if (m_tvalid && m_tready) begin
        check("beat_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", m_tdata, e.data);
          check("out_last", m_tlast, e.last);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (o_tx_done) tx_cnt++;
      if (o_rx_done) rx_cnt++;
    end
  end

  task automatic pulse_start(input logic sc, input logic [CH-1:0] scm, input logic [CH-1:0] o,
                             input int sl, input int fnm);
    @(posedge clk); #1;
    single_channel = sc;
    single_channel_mask = scm;
    oen = o;
    send_len = 32'(sl);
    frame_num_max = 32'(fnm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int guard = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      guard++;
      if (guard > 5000) begin
        check("s_ready_timeout", s_tready, 1);
        break;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  // Reference: the output is the input word list, cut at frame_num_max, packed W per beat, zero padded.
  task automatic predict(input logic [31:0] words[$], input int fnm, input bit with_last);
    int tot = words.size();
    int n = (fnm != 0 && fnm < tot) ? fnm : tot;
    for (int b = 0; b * W < n; b++) begin
      beat_t e;
      e.data = '0;
      e.last = 1'b0;
      for (int k = 0; k < W; k++) begin
        int idx = b * W + k;
        if (idx < n) e.data[32*k +: 32] = words[idx];
        if (idx == n - 1) e.last = with_last && (fnm == 0 || fnm <= tot);
      end
      exp_q.push_back(e);
    end
    exp_drop = tot - n;
  endtask

  task automatic run_case(input string tag, input logic sc, input logic [CH-1:0] scm,
                          input logic [CH-1:0] o, input int sl, input int fnm, input int mode,
                          input bit fixed);
    logic [31:0] words[$];
    logic [DW-1:0] beats[$];
    int guard = 0;
    for (int b = 0; b < sl; b++) begin
      logic [DW-1:0] d;
      for (int k = 0; k < W; k++) begin
        logic [31:0] w;
        w = fixed ? 32'(b * W + k) : $urandom();
        d[32*k +: 32] = w;
        words.push_back(w);
      end
      beats.push_back(d);
    end
    predict(words, fnm, 1'b1);
    ready_mode = mode;
    stall_cnt = 0;
    tx_cnt = 0;
    rx_cnt = 0;
    pulse_start(sc, scm, o, sl, fnm);
    if (sl == 0) begin
      @(negedge clk);
      check({tag, "_tx_after_start"}, o_tx_done, 1);
    end
    fork
      begin
        foreach (beats[i]) send_beat(beats[i]);
      end
      begin
        if (mode == 3) begin
          repeat (190) @(negedge clk);
          check({tag, "_stall_s_tready"}, s_tready, 0);
        end
      end
    join
    while (rx_cnt == 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_rx_seen"}, (rx_cnt != 0), 1);
    check({tag, "_tx_pulses"}, tx_cnt, 1);
    check({tag, "_rx_pulses"}, rx_cnt, 1);
    check({tag, "_left_expected"}, exp_q.size(), 0);
`ifdef PAICORE_LOOPBACK_STATS_EN
    check({tag, "_drop_cnt"}, o_drop_cnt, exp_drop);
`endif
    @(negedge clk);
    check({tag, "_idle_busy"}, o_busy, 0);
    check({tag, "_rx_one_cycle"}, o_rx_done, 0);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; single_channel = 1'b0; oen = '0; single_channel_mask = '0;
    send_len = '0; frame_num_max = '0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tdata", m_tdata, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_busy", o_busy, 0);
    rst = 1'b0;

    run_case("basic", 1'b0, '0, 4'b1111, 4, 8, 0, 1'b1);
    run_case("single", 1'b1, 4'b0100, 4'b0011, 20, 0, 1, 1'b0);
    run_case("limit", 1'b0, '0, 4'b1111, 3, 5, 0, 1'b1);
    run_case("stall", 1'b0, '0, 4'b1111, 20, 0, 3, 1'b0);
    run_case("zero_len", 1'b0, '0, 4'b1111, 0, 0, 0, 1'b0);

    // A start with an empty mask must be ignored.
    pulse_start(1'b0, 4'b1111, '0, 4, 0);
    repeat (3) @(negedge clk);
    check("zero_mask_busy", o_busy, 0);
    check("zero_mask_s_tready", s_tready, 0);

    // Abort after 2 of 10 beats; beats already produced must still match the word order.
    begin
      logic [31:0] words[$];
      for (int i = 0; i < 2 * W; i++) words.push_back(32'hA000_0000 + 32'(i));
      predict(words, 0, 1'b0);
      ready_mode = 0;
      tx_cnt = 0;
      rx_cnt = 0;
      pulse_start(1'b0, '0, 4'b1011, 10, 0);
      for (int b = 0; b < 2; b++) send_beat({words[2*b+1], words[2*b]});
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_tdata", m_tdata, 0);
      check("abort_tvalid", m_tvalid, 0);
      check("abort_tlast", m_tlast, 0);
      check("abort_s_tready", s_tready, 0);
      check("abort_busy", o_busy, 0);
      check("abort_done_pulses", {o_tx_done, o_rx_done}, 0);
      check("abort_tx_cnt", tx_cnt, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("abort_no_rerun", o_busy, 0);
      check("abort_rx_cnt", rx_cnt, 0);
    end
    run_case("after_abort", 1'b0, '0, 4'b1111, 2, 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      logic [CH-1:0] m, other;
      logic sc;
      int sl, fnm;
      m = CH'($urandom_range(1, (1 << CH) - 1));
      other = CH'($urandom());
      sc = 1'($urandom_range(0, 1));
      sl = $urandom_range(1, 12);
      fnm = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, sl * W);
      if (sc) run_case("rand", 1'b1, m, other, sl, fnm, $urandom_range(0, 2), 1'b0);
      else    run_case("rand", 1'b0, other, m, sl, fnm, $urandom_range(0, 2), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
